chacha20_poly1305_bus_seq: RTL and testbench

- Bus-master sequencer that drives the cs/we/address/write_data/read_data register port of chacha20_poly1305_bus.
- Per session:
  - programs key (0x10–0x17) and nonce (0x20–0x22);
  - issues init and polls status;
  - per 512-bit block: streams 16 input words to 0x30–0x3F, issues next, polls status, streams 16 result words out of 0x40–0x4F;
  - issues done after the last block.
- Sits between a stream-style host and the crypto core, so software never sequences individual register accesses.

---
 rtl/chacha20_poly1305_bus_seq.sv | 247 ++++++++++++++++++++++++
 tb/tb_chacha20_poly1305_bus_seq.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha20_poly1305_bus_seq.sv
// Register-port bus master that runs a full ChaCha20-Poly1305 session: key/nonce programming,
// init, per-block load/next/readout, and a final done command, with poll-timeout recovery.
module chacha20_poly1305_bus_seq #(
   parameter int POLL_TIMEOUT = 1024,
   parameter int READY_BIT    = 0,
   parameter int BLOCK_WORDS  = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [255:0] key,
   input  logic [95:0]  nonce,
   input  logic         in_valid,
   input  logic [31:0]  in_data,
   input  logic         in_last,
   output logic         in_ready,
   output logic         out_valid,
   output logic [31:0]  out_data,
   input  logic         out_ready,
   output logic         busy,
   output logic         done,
   output logic         error,
   output logic         bus_cs,
   output logic         bus_we,
   output logic [7:0]   bus_addr,
   output logic [31:0]  bus_wdata,
   input  logic [31:0]  bus_rdata
);

   localparam int CW = $clog2(BLOCK_WORDS);
   localparam int PW = $clog2(POLL_TIMEOUT + 1);

   typedef enum logic [3:0] {
      IDLE, WR_KEY, WR_NONCE, WR_INIT, POLL_INIT, LOAD,
      WR_NEXT, POLL_NEXT, READ_OUT, WR_DONE, ERR
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [PW-1:0]  poll_q, poll_d;
   logic [255:0]   keyShift_q, keyShift_d;
   logic [95:0]    nonceShift_q, nonceShift_d;
   logic           last_q, last_d;
   logic           outValid_q, outValid_d;
   logic [31:0]    outData_q, outData_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           error_q, error_d;
   logic           busCs_q, busCs_d;
   logic           busWe_q, busWe_d;
   logic [7:0]     busAddr_q, busAddr_d;
   logic [31:0]    busWdata_q, busWdata_d;
   logic           rdActive;

   // A read is on the bus this cycle; its data is consumed at the closing edge.
   assign rdActive = busCs_q && !busWe_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      poll_d       = poll_q;
      keyShift_d   = keyShift_q;
      nonceShift_d = nonceShift_q;
      last_d       = last_q;
      outValid_d   = outValid_q;
      outData_d    = outData_q;
      error_d      = error_q;
      done_d       = 1'b0;
      busCs_d      = 1'b0;
      busWe_d      = 1'b0;
      busAddr_d    = 8'h00;
      busWdata_d   = 32'h0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = WR_KEY;
               cnt_d        = '0;
               keyShift_d   = key;
               nonceShift_d = nonce;
               error_d      = 1'b0;
            end
         end
         WR_KEY: begin
            busCs_d    = 1'b1;
            busWe_d    = 1'b1;
            busAddr_d  = 8'h10 + 8'(cnt_q);
            busWdata_d = keyShift_q[255:224];
            keyShift_d = {keyShift_q[223:0], 32'h0};
            if (cnt_q == CW'(7)) begin
               cnt_d   = '0;
               state_d = WR_NONCE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         WR_NONCE: begin
            busCs_d      = 1'b1;
            busWe_d      = 1'b1;
            busAddr_d    = 8'h20 + 8'(cnt_q);
            busWdata_d   = nonceShift_q[95:64];
            nonceShift_d = {nonceShift_q[63:0], 32'h0};
            if (cnt_q == CW'(2)) begin
               cnt_d   = '0;
               state_d = WR_INIT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         WR_INIT: begin
            busCs_d    = 1'b1;
            busWe_d    = 1'b1;
            busAddr_d  = 8'h08;
            busWdata_d = 32'h0000_0001;
            poll_d     = '0;
            state_d    = POLL_INIT;
         end
         // Readiness is judged on the read currently on the bus; the first READ_OUT read is issued on exit.
         POLL_INIT, POLL_NEXT: begin
            if (rdActive && bus_rdata[READY_BIT]) begin
               cnt_d = '0;
               if (state_q == POLL_INIT) begin
                  state_d = LOAD;
               end else begin
                  state_d   = READ_OUT;
                  busCs_d   = 1'b1;
                  busAddr_d = 8'h40;
               end
            end else if (poll_q == PW'(POLL_TIMEOUT)) begin
               state_d = ERR;
            end else begin
               busCs_d   = 1'b1;
               busAddr_d = 8'h09;
               poll_d    = poll_q + PW'(1);
            end
         end
         LOAD: begin
            if (in_valid) begin
               busCs_d    = 1'b1;
               busWe_d    = 1'b1;
               busAddr_d  = 8'h30 + 8'(cnt_q);
               busWdata_d = in_data;
               if (cnt_q == CW'(BLOCK_WORDS - 1)) begin
                  last_d  = in_last;
                  cnt_d   = '0;
                  state_d = WR_NEXT;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         WR_NEXT: begin
            busCs_d    = 1'b1;
            busWe_d    = 1'b1;
            busAddr_d  = 8'h08;
            busWdata_d = 32'h0000_0002;
            poll_d     = '0;
            state_d    = POLL_NEXT;
         end
         READ_OUT: begin
            if (outValid_q) begin
               if (out_ready) begin
                  outValid_d = 1'b0;
                  if (cnt_q == CW'(BLOCK_WORDS - 1)) begin
                     cnt_d   = '0;
                     state_d = last_q ? WR_DONE : LOAD;
                  end else begin
                     cnt_d     = cnt_q + CW'(1);
                     busCs_d   = 1'b1;
                     busAddr_d = 8'h40 + 8'(cnt_q + CW'(1));
                  end
               end
            end else if (rdActive) begin
               outValid_d = 1'b1;
               outData_d  = bus_rdata;
            end
         end
         WR_DONE: begin
            busCs_d    = 1'b1;
            busWe_d    = 1'b1;
            busAddr_d  = 8'h08;
            busWdata_d = 32'h0000_0004;
            done_d     = 1'b1;
            state_d    = IDLE;
         end
         ERR: begin
            busCs_d    = 1'b1;
            busWe_d    = 1'b1;
            busAddr_d  = 8'h08;
            busWdata_d = 32'h0000_0000;
            error_d    = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         poll_q       <= '0;
         keyShift_q   <= '0;
         nonceShift_q <= '0;
         last_q       <= 1'b0;
         outValid_q   <= 1'b0;
         outData_q    <= 32'h0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         busCs_q      <= 1'b0;
         busWe_q      <= 1'b0;
         busAddr_q    <= 8'h00;
         busWdata_q   <= 32'h0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         poll_q       <= poll_d;
         keyShift_q   <= keyShift_d;
         nonceShift_q <= nonceShift_d;
         last_q       <= last_d;
         outValid_q   <= outValid_d;
         outData_q    <= outData_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
         busCs_q      <= busCs_d;
         busWe_q      <= busWe_d;
         busAddr_q    <= busAddr_d;
         busWdata_q   <= busWdata_d;
      end
   end

   assign in_ready  = (state_q == LOAD);
   assign out_valid = outValid_q;
   assign out_data  = outData_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;
   assign bus_cs    = busCs_q;
   assign bus_we    = busWe_q;
   assign bus_addr  = busAddr_q;
   assign bus_wdata = busWdata_q;

endmodule

// File: tb/tb_chacha20_poly1305_bus_seq.sv
// Scoreboard bench for chacha20_poly1305_bus_seq against a small register-port core model.
module tb_chacha20_poly1305_bus_seq;

   localparam int TIMEOUT = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [255:0] key;
   logic [95:0]  nonce;
   logic         in_valid;
   logic [31:0]  in_data;
   logic         in_last;
   logic         in_ready;
   logic         out_valid;
   logic [31:0]  out_data;
   logic         out_ready;
   logic         busy;
   logic         done;
   logic         error;
   logic         bus_cs;
   logic         bus_we;
   logic [7:0]   bus_addr;
   logic [31:0]  bus_wdata;
   logic [31:0]  bus_rdata;

   logic         coreReady;
   int           errors = 0;
   int           checks = 0;
   int           cycle = 0;
   int           outCount = 0;

   typedef struct {
      logic        we;
      logic [7:0]  addr;
      logic [31:0] data;
      int          cyc;
   } busTx_t;

   busTx_t       expBus[$];
   busTx_t       actLog[$];
   logic [31:0]  expOut[$];

   localparam logic [255:0] KEY_A = 256'h00112233_44556677_8899aabb_ccddeeff_01234567_89abcdef_deadbeef_feedface;
   localparam logic [95:0]  NONCE_A = 96'h01010101_02020202_03030303;

   chacha20_poly1305_bus_seq #(.POLL_TIMEOUT(TIMEOUT), .READY_BIT(0), .BLOCK_WORDS(16)) dut (
      .clk(clk), .rst(rst), .start(start), .key(key), .nonce(nonce),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .busy(busy), .done(done), .error(error),
      .bus_cs(bus_cs), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   // Core model: status register reports coreReady, result window returns 0xC0DE0000+index.
   always_comb begin
      bus_rdata = 32'h0;
      if (bus_cs && !bus_we) begin
         if (bus_addr == 8'h09)
            bus_rdata = {31'h0, coreReady};
         else if (bus_addr[7:4] == 4'h4)
            bus_rdata = 32'hC0DE0000 | {28'h0, bus_addr[3:0]};
      end
   end

   task automatic expWrite(input logic [7:0] a, input logic [31:0] d);
      busTx_t t;
      t.we = 1'b1; t.addr = a; t.data = d; t.cyc = 0;
      expBus.push_back(t);
   endtask

   task automatic expRead(input logic [7:0] a);
      busTx_t t;
      t.we = 1'b0; t.addr = a; t.data = 32'h0; t.cyc = 0;
      expBus.push_back(t);
   endtask

   task automatic expHeader(input logic [255:0] k, input logic [95:0] n);
      for (int i = 0; i < 8; i++) expWrite(8'h10 + 8'(i), k[255-32*i -: 32]);
      for (int i = 0; i < 3; i++) expWrite(8'h20 + 8'(i), n[95-32*i -: 32]);
      expWrite(8'h08, 32'h1);
   endtask

   task automatic clearLogs();
      expBus.delete();
      expOut.delete();
      actLog.delete();
   endtask

   // Advance to the next falling edge and score any bus access presented this cycle.
   task automatic tick();
      busTx_t a, e;
      @(negedge clk);
      cycle++;
      if (!rst && bus_cs) begin
         a.we = bus_we; a.addr = bus_addr; a.data = bus_we ? bus_wdata : 32'h0; a.cyc = cycle;
         actLog.push_back(a);
         checks++;
         if (expBus.size() == 0) begin
            errors++;
            $display("[TB] FAIL bus_extra: actual we=%b addr=%02h data=%08h, required no access", a.we, a.addr, a.data);
         end else begin
            e = expBus.pop_front();
            if (a.we !== e.we || a.addr !== e.addr || a.data !== e.data) begin
               errors++;
               $display("[TB] FAIL bus_trace: actual we=%b addr=%02h data=%08h, required we=%b addr=%02h data=%08h",
                        a.we, a.addr, a.data, e.we, e.addr, e.data);
            end
         end
      end
   endtask

   task automatic pulseStart();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic applyStimulus(input logic [31:0] w [16], input bit last);
      int k;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_data  = w[i];
         in_last  = last && (i == 15);
         k = 0;
         while (!in_ready && k < 100) begin tick(); k++; end
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_ready word %0d: actual in_ready=%b, required 1", i, in_ready);
            break;
         end
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 32'h0;
   endtask

   task automatic receiveBlock(input bit toggle, input int stopAt);
      int got, k;
      bit hold;
      logic [31:0] heldData, exp;
      got = 0; k = 0; hold = 1'b0; heldData = 32'h0;
      while (got < 16 && got != stopAt && k < 400) begin
         if (hold) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== heldData) begin
               errors++;
               $display("[TB] FAIL out_hold: actual valid=%b data=%08h, required valid=1 data=%08h", out_valid, out_data, heldData);
            end
         end
         out_ready = toggle ? ~out_ready : 1'b1;
         if (out_valid && out_ready) begin
            checks++;
            if (expOut.size() == 0) begin
               errors++;
               $display("[TB] FAIL out_extra: actual %08h, required no word", out_data);
            end else begin
               exp = expOut.pop_front();
               if (out_data !== exp) begin
                  errors++;
                  $display("[TB] FAIL out_data: actual %08h, required %08h", out_data, exp);
               end
            end
            got++;
            outCount++;
         end
         hold = out_valid && !out_ready;
         heldData = out_data;
         tick();
         k++;
      end
      out_ready = 1'b0;
      if (stopAt < 0) begin
         checks++;
         if (got != 16) begin
            errors++;
            $display("[TB] FAIL out_count: actual %0d words, required 16", got);
         end
      end
   endtask

   task automatic runSession(input logic [255:0] k, input logic [95:0] n, input int nBlocks,
                             input bit toggle, input bit restartInLoad, input int abortAt);
      logic [31:0] w [16];
      bit seen, busyAt;
      int kk;
      coreReady = 1'b1;
      expHeader(k, n);
      expRead(8'h09);
      key = k;
      nonce = n;
      pulseStart();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL start_busy: actual %b, required 1", busy); end
      checks++;
      if (error !== 1'b0) begin errors++; $display("[TB] FAIL start_error: actual %b, required 0", error); end
      for (int b = 0; b < nBlocks; b++) begin
         for (int i = 0; i < 16; i++)
            w[i] = (b == 0) ? ((i == 0) ? 32'haaaaaaaa : (i == 1) ? 32'hbbbbbbbb : 32'h0) : $urandom;
         for (int i = 0; i < 16; i++) expWrite(8'h30 + 8'(i), w[i]);
         expWrite(8'h08, 32'h2);
         expRead(8'h09);
         for (int i = 0; i < 16; i++) begin
            expRead(8'h40 + 8'(i));
            expOut.push_back(32'hC0DE0000 + 32'(i));
         end
         if (b == nBlocks - 1) expWrite(8'h08, 32'h4);
         if (restartInLoad && b == 0) begin
            kk = 0;
            while (!in_ready && kk < 100) begin tick(); kk++; end
            key = ~k;
            nonce = ~n;
            pulseStart();
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b1) begin
               errors++;
               $display("[TB] FAIL restart_ignored: actual busy=%b in_ready=%b, required 1 1", busy, in_ready);
            end
         end
         applyStimulus(w, b == nBlocks - 1);
         receiveBlock(toggle, (b == 0) ? abortAt : -1);
         if (abortAt >= 0) return;
      end
      seen = 1'b0; busyAt = 1'b1; kk = 0;
      while (!seen && kk < 50) begin
         if (done === 1'b1) begin seen = 1'b1; busyAt = busy; end
         else begin tick(); kk++; end
      end
      checks++;
      if (!seen) begin errors++; $display("[TB] FAIL done_pulse: actual none, required done=1"); end
      checks++;
      if (busyAt !== 1'b0) begin errors++; $display("[TB] FAIL busy_at_done: actual %b, required 0", busyAt); end
      tick();
      checks++;
      if (done !== 1'b0) begin errors++; $display("[TB] FAIL done_width: actual %b, required 0", done); end
      checks++;
      if (expBus.size() != 0) begin errors++; $display("[TB] FAIL bus_missing: actual %0d pending, required 0", expBus.size()); end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; key = '0; nonce = '0; in_valid = 1'b0; in_data = 32'h0;
      in_last = 1'b0; out_ready = 1'b0; coreReady = 1'b1;
      tick(); tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: actual %b, required 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done: actual %b, required 0", done); end
      checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL rst_error: actual %b, required 0", error); end
      checks++; if (bus_cs !== 1'b0 || bus_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_bus: actual cs=%b we=%b, required 0 0", bus_cs, bus_we); end
      checks++; if (bus_addr !== 8'h0 || bus_wdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_busdata: actual %02h %08h, required 00 00000000", bus_addr, bus_wdata); end
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_hs: actual in_ready=%b out_valid=%b, required 0 0", in_ready, out_valid); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_out_data: actual %08h, required 00000000", out_data); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_block();
      clearLogs();
      runSession(KEY_A, NONCE_A, 1, 1'b0, 1'b0, -1);
      checks++;
      if (actLog.size() != 48) begin
         errors++;
         $display("[TB] FAIL single_trace_len: actual %0d, required 48", actLog.size());
      end else begin
         checks++;
         if (actLog[11].cyc - actLog[0].cyc != 11) begin
            errors++; $display("[TB] FAIL header_consecutive: actual span %0d, required 11", actLog[11].cyc - actLog[0].cyc);
         end
         checks++;
         if (actLog[28].cyc - actLog[13].cyc != 15) begin
            errors++; $display("[TB] FAIL load_consecutive: actual span %0d, required 15", actLog[28].cyc - actLog[13].cyc);
         end
      end
   endtask

   task automatic test_two_blocks();
      int doneWrites;
      clearLogs();
      outCount = 0;
      runSession(~KEY_A, ~NONCE_A, 2, 1'b1, 1'b0, -1);
      doneWrites = 0;
      foreach (actLog[i]) if (actLog[i].we && actLog[i].addr == 8'h08 && actLog[i].data == 32'h4) doneWrites++;
      checks++;
      if (outCount != 32) begin errors++; $display("[TB] FAIL two_out_count: actual %0d, required 32", outCount); end
      checks++;
      if (doneWrites != 1) begin errors++; $display("[TB] FAIL two_done_writes: actual %0d, required 1", doneWrites); end
   endtask

   task automatic test_timeout();
      int polls, kk;
      bit doneSeen;
      clearLogs();
      coreReady = 1'b0;
      expHeader(KEY_A, NONCE_A);
      for (int i = 0; i < TIMEOUT; i++) expRead(8'h09);
      expWrite(8'h08, 32'h0);
      key = KEY_A;
      nonce = NONCE_A;
      pulseStart();
      doneSeen = 1'b0; kk = 0;
      while (busy === 1'b1 && kk < 100) begin tick(); kk++; doneSeen |= (done === 1'b1); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL to_busy: actual %b, required 0", busy); end
      checks++; if (error !== 1'b1) begin errors++; $display("[TB] FAIL to_error: actual %b, required 1", error); end
      checks++; if (doneSeen) begin errors++; $display("[TB] FAIL to_done: actual 1, required 0"); end
      polls = 0;
      foreach (actLog[i]) if (!actLog[i].we && actLog[i].addr == 8'h09) polls++;
      checks++; if (polls != TIMEOUT) begin errors++; $display("[TB] FAIL to_polls: actual %0d, required %0d", polls, TIMEOUT); end
      checks++; if (expBus.size() != 0) begin errors++; $display("[TB] FAIL to_pending: actual %0d, required 0", expBus.size()); end
      tick(); tick();
      checks++; if (error !== 1'b1) begin errors++; $display("[TB] FAIL to_sticky: actual %b, required 1", error); end
      clearLogs();
      runSession(KEY_A, NONCE_A, 1, 1'b0, 1'b0, -1);
   endtask

   task automatic test_start_during_load();
      clearLogs();
      runSession(KEY_A, ~NONCE_A, 1, 1'b0, 1'b1, -1);
   endtask

   task automatic test_reset_mid();
      for (int pass = 0; pass < 2; pass++) begin
         clearLogs();
         runSession(KEY_A, NONCE_A, 1, 1'b0, 1'b0, 5);
         if (pass == 1) tick();
         checks++;
         if ((pass == 0) ? (bus_cs !== 1'b1) : (out_valid !== 1'b1)) begin
            errors++; $display("[TB] FAIL rstmid_pre%0d: actual cs=%b valid=%b, required active", pass, bus_cs, out_valid);
         end
         #2 rst = 1'b1;
         #1;
         checks++;
         if (bus_cs !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL rstmid_async%0d: actual cs=%b valid=%b busy=%b, required 0 0 0", pass, bus_cs, out_valid, busy);
         end
         tick();
         rst = 1'b0;
         tick();
      end
      clearLogs();
      runSession(KEY_A, NONCE_A, 1, 1'b0, 1'b0, -1);
      checks++;
      if (actLog.size() == 0 || actLog[0].addr !== 8'h10 || actLog[0].we !== 1'b1) begin
         errors++; $display("[TB] FAIL rstmid_restart: first access not write 10, required write 10");
      end
   endtask

   initial begin
      test_reset();
      test_single_block();
      test_two_blocks();
      test_timeout();
      test_start_during_load();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation still running, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
